// File: rtl/rgb_tile_order.sv
// rgb_tile_order
//
// Sequential nearest-colour classifier. Captures N_TILES averaged tile colours
// and matches each one against an N_TILES-entry palette by minimum Manhattan
// RGB distance. One palette compare is done per clock. The result is the
// matched palette index of every tile, plus a miss flag and a duplicate flag.
//
// Optional feature macro: RGB_TILE_DUP_CHECK_EN
//   defined   : a CHECK pass of N_TILES cycles builds a seen-vector and drives o_dup
//   undefined : the FSM goes SCAN -> DONE and o_dup is tied low
//
// Parameters
//   N_TILES  tiles per frame and palette depth (>= 2)
//   CH_W     bits per colour channel
//   IDX_W    index width, derived from N_TILES (leave at default)
//   TOL      largest accepted best-match distance
//
// Ports
//   i_clk       rising-edge clock
//   i_rst       asynchronous active-high reset (also restores the default palette)
//   i_start     frame request, sampled only in IDLE
//   i_blocks    tile t colour at [t*3*CH_W +: 3*CH_W], packed {R,G,B}
//   i_pal_we    palette write strobe, honoured only in IDLE
//   i_pal_addr  palette entry to write
//   i_pal_data  palette colour {R,G,B}
//   o_busy      high while scanning/checking
//   o_done      one-cycle pulse when the result outputs update
//   o_order     matched index of tile t at [t*IDX_W +: IDX_W]
//   o_miss      some tile's best distance exceeded TOL
//   o_dup       two tiles matched the same index
module rgb_tile_order #(
   parameter int N_TILES = 16,
   parameter int CH_W    = 8,
   parameter int IDX_W   = $clog2(N_TILES),
   parameter int TOL     = 48
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic [N_TILES*3*CH_W-1:0]  i_blocks,
   input  logic                       i_pal_we,
   input  logic [IDX_W-1:0]           i_pal_addr,
   input  logic [3*CH_W-1:0]          i_pal_data,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [N_TILES*IDX_W-1:0]   o_order,
   output logic                       o_miss,
   output logic                       o_dup
);

   localparam int PIX_W  = 3 * CH_W;
   localparam int DIST_W = CH_W + 2;
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_TILES - 1);
   localparam logic [DIST_W-1:0] TOL_D = DIST_W'(TOL);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Palette reset component: code 0 -> 00, 1 -> half scale minus one, 2 -> full scale
   function automatic logic [CH_W-1:0] comp_of(input logic [1:0] code);
      logic [CH_W-1:0] v;
      case (code)
         2'd0:    v = '0;
         2'd1:    v = {1'b0, {(CH_W-1){1'b1}}};
         default: v = '1;
      endcase
      return v;
   endfunction

   function automatic logic [PIX_W-1:0] pal_default(input int idx);
      logic [5:0] c;
      logic       valid;
      valid = 1'b1;
      case (idx)
         0:       c = 6'b10_01_10;
         1:       c = 6'b10_10_10;
         2:       c = 6'b10_10_00;
         3:       c = 6'b10_01_00;
         4:       c = 6'b10_00_01;
         5:       c = 6'b10_00_00;
         6:       c = 6'b01_10_01;
         7:       c = 6'b01_01_00;
         8:       c = 6'b01_00_10;
         9:       c = 6'b01_00_00;
         10:      c = 6'b00_10_10;
         11:      c = 6'b00_10_00;
         12:      c = 6'b00_01_10;
         13:      c = 6'b00_01_00;
         14:      c = 6'b00_00_01;
         15:      c = 6'b00_00_00;
         default: begin
            c     = 6'b00_00_00;
            valid = 1'b0;
         end
      endcase
      if (!valid) return '0;
      return {comp_of(c[5:4]), comp_of(c[3:2]), comp_of(c[1:0])};
   endfunction

   function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                                 input logic [CH_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // Sum of three CH_W-bit magnitudes always fits in CH_W+2 bits
   function automatic logic [DIST_W-1:0] manhattan(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b);
      logic [DIST_W-1:0] dr, dg, db;
      dr = DIST_W'(abs_diff(a[3*CH_W-1:2*CH_W], b[3*CH_W-1:2*CH_W]));
      dg = DIST_W'(abs_diff(a[2*CH_W-1:CH_W],   b[2*CH_W-1:CH_W]));
      db = DIST_W'(abs_diff(a[CH_W-1:0],        b[CH_W-1:0]));
      return dr + dg + db;
   endfunction

   // Control state
   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           t_q, t_d;
   logic [IDX_W-1:0]           p_q, p_d;
   logic                       done_q, done_d;
   logic [N_TILES*IDX_W-1:0]   order_q, order_d;
   logic                       miss_q, miss_d;

   // Datapath state
   logic [N_TILES*PIX_W-1:0]   blocks_q, blocks_d;
   logic [DIST_W-1:0]          best_q, best_d;
   logic [IDX_W-1:0]           best_idx_q, best_idx_d;
   logic [N_TILES*IDX_W-1:0]   order_sh_q, order_sh_d;
   logic                       miss_sh_q, miss_sh_d;

   logic [PIX_W-1:0]           pal_q [N_TILES];
   logic                       pal_wr;

   logic [PIX_W-1:0]           cur_pix;
   logic [DIST_W-1:0]          cur_dist;
   logic                       better;
   logic [DIST_W-1:0]          fin_dist;
   logic [IDX_W-1:0]           fin_idx;

`ifdef RGB_TILE_DUP_CHECK_EN
   logic                       dup_q, dup_d;
   logic                       dup_sh_q, dup_sh_d;
   logic [N_TILES-1:0]         seen_q, seen_d;
   logic [IDX_W-1:0]           chk_idx;
`endif

   // Palette: writes only while idle, so an accepted start sees a same-edge write
   assign pal_wr = (state_q == S_IDLE) && i_pal_we;

   for (genvar g = 0; g < N_TILES; g++) begin : g_pal
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            pal_q[g] <= pal_default(g);
         end else if (pal_wr && (i_pal_addr == IDX_W'(g))) begin
            pal_q[g] <= i_pal_data;
         end
      end
   end

   // Compare of the current tile against the current palette entry
   assign cur_pix  = blocks_q[t_q*PIX_W +: PIX_W];
   assign cur_dist = manhattan(cur_pix, pal_q[p_q]);
   // Strict less-than: on a tie the earlier (lower) palette index is kept
   assign better   = (cur_dist < best_q);
   assign fin_dist = better ? cur_dist : best_q;
   assign fin_idx  = better ? p_q : best_idx_q;

`ifdef RGB_TILE_DUP_CHECK_EN
   assign chk_idx = order_sh_q[t_q*IDX_W +: IDX_W];
`endif

   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      p_d        = p_q;
      done_d     = 1'b0;
      order_d    = order_q;
      miss_d     = miss_q;
      blocks_d   = blocks_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      order_sh_d = order_sh_q;
      miss_sh_d  = miss_sh_q;
`ifdef RGB_TILE_DUP_CHECK_EN
      dup_d      = dup_q;
      dup_sh_d   = dup_sh_q;
      seen_d     = seen_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               blocks_d   = i_blocks;
               t_d        = '0;
               p_d        = '0;
               best_d     = '1;
               best_idx_d = '0;
               miss_sh_d  = 1'b0;
`ifdef RGB_TILE_DUP_CHECK_EN
               dup_sh_d   = 1'b0;
               seen_d     = '0;
`endif
               state_d    = S_SCAN;
            end
         end

         S_SCAN: begin
            if (p_q == LAST) begin
               // Last palette entry for this tile: retire the tile's best match
               order_sh_d[t_q*IDX_W +: IDX_W] = fin_idx;
               if (fin_dist > TOL_D) miss_sh_d = 1'b1;
               best_d     = '1;
               best_idx_d = '0;
               p_d        = '0;
               if (t_q == LAST) begin
                  t_d = '0;
`ifdef RGB_TILE_DUP_CHECK_EN
                  state_d = S_CHECK;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  t_d = t_q + 1'b1;
               end
            end else begin
               best_d     = fin_dist;
               best_idx_d = fin_idx;
               p_d        = p_q + 1'b1;
            end
         end

`ifdef RGB_TILE_DUP_CHECK_EN
         S_CHECK: begin
            // t_q doubles as the check step k
            if (seen_q[chk_idx]) dup_sh_d = 1'b1;
            seen_d[chk_idx] = 1'b1;
            if (t_q == LAST) begin
               t_d     = '0;
               state_d = S_DONE;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
`endif

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Results are published on the edge that enters DONE so they appear with o_done
      if (state_d == S_DONE) begin
         done_d  = 1'b1;
         order_d = order_sh_d;
         miss_d  = miss_sh_d;
`ifdef RGB_TILE_DUP_CHECK_EN
         dup_d   = dup_sh_d;
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
         order_q <= '0;
         miss_q  <= 1'b0;
`ifdef RGB_TILE_DUP_CHECK_EN
         dup_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         p_q     <= p_d;
         done_q  <= done_d;
         order_q <= order_d;
         miss_q  <= miss_d;
`ifdef RGB_TILE_DUP_CHECK_EN
         dup_q   <= dup_d;
`endif
      end
   end

   // Working registers are (re)initialised on every accepted start
   always_ff @(posedge i_clk) begin
      blocks_q   <= blocks_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      order_sh_q <= order_sh_d;
      miss_sh_q  <= miss_sh_d;
`ifdef RGB_TILE_DUP_CHECK_EN
      dup_sh_q   <= dup_sh_d;
      seen_q     <= seen_d;
`endif
   end

   // DONE is a publish cycle, so busy covers only SCAN and CHECK
   assign o_busy  = (state_q == S_SCAN) || (state_q == S_CHECK);
   assign o_done  = done_q;
   assign o_order = order_q;
   assign o_miss  = miss_q;
`ifdef RGB_TILE_DUP_CHECK_EN
   assign o_dup   = dup_q;
`else
   assign o_dup   = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_tile_order.sv
module tb_rgb_tile_order;

   localparam int N = 16;
`ifdef RGB_TILE_DUP_CHECK_EN
   localparam int LAT = 273;
`else
   localparam int LAT = 257;
`endif
   localparam int WIN = 600;

   logic          clk;
   logic          i_rst;
   logic          i_start;
   logic [383:0]  i_blocks;
   logic          i_pal_we;
   logic [3:0]    i_pal_addr;
   logic [23:0]   i_pal_data;
   logic          o_busy;
   logic          o_done;
   logic [63:0]   o_order;
   logic          o_miss;
   logic          o_dup;

   int checks = 0;
   int errors = 0;

   logic [23:0] pal_tab [16] = '{24'hff7fff, 24'hffffff, 24'hffff00, 24'hff7f00,
                                 24'hff007f, 24'hff0000, 24'h7fff7f, 24'h7f7f00,
                                 24'h7f00ff, 24'h7f0000, 24'h00ffff, 24'h00ff00,
                                 24'h007fff, 24'h007f00, 24'h00007f, 24'h000000};
   int perm [16] = '{12, 10, 14, 0, 8, 4, 6, 2, 13, 11, 15, 1, 7, 3, 5, 9};
   int exp_idx [16];

   rgb_tile_order #(.N_TILES(16), .CH_W(8), .TOL(48)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_blocks   (i_blocks),
      .i_pal_we   (i_pal_we),
      .i_pal_addr (i_pal_addr),
      .i_pal_data (i_pal_data),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_order    (o_order),
      .o_miss     (o_miss),
      .o_dup      (o_dup)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic dupx(input logic v);
`ifdef RGB_TILE_DUP_CHECK_EN
      return v;
`else
      return 1'b0 & v;
`endif
   endfunction

   function automatic logic [383:0] perm_blocks();
      logic [383:0] b;
      b = '0;
      for (int t = 0; t < N; t++) b[t*24 +: 24] = pal_tab[perm[t]];
      return b;
   endfunction

   function automatic logic [63:0] pack_exp();
      logic [63:0] o;
      o = '0;
      for (int t = 0; t < N; t++) o[t*4 +: 4] = 4'(exp_idx[t]);
      return o;
   endfunction

   function automatic void exp_from_perm();
      for (int t = 0; t < N; t++) exp_idx[t] = perm[t];
   endfunction

   // Move every channel 10 counts towards mid-scale or alternately up/down
   function automatic logic [383:0] add_noise(input logic [383:0] b);
      logic [383:0] r;
      logic [7:0]   v;
      r = b;
      for (int t = 0; t < N; t++) begin
         for (int c = 0; c < 3; c++) begin
            v = b[t*24 + c*8 +: 8];
            if (v == 8'hff)           v = v - 8'd10;
            else if (v == 8'h00)      v = v + 8'd10;
            else if (((t + c) % 2) == 1) v = v + 8'd10;
            else                      v = v - 8'd10;
            r[t*24 + c*8 +: 8] = v;
         end
      end
      return r;
   endfunction

   task automatic pal_write(input logic [3:0] addr, input logic [23:0] data);
      i_pal_we   = 1'b1;
      i_pal_addr = addr;
      i_pal_data = data;
      @(posedge clk);
      #1;
      i_pal_we   = 1'b0;
   endtask

   // Start a frame and watch a fixed window. pulse_at: cycle at which a stray
   // start and a palette write (entry 1 = 000001) are driven. rst_at: cycle at
   // which reset is asserted. Cycle 1 is the cycle after the start edge.
   task automatic run_frame(input logic [383:0] blk, input int pulse_at, input int rst_at,
                            output int done_cyc, output int n_done,
                            output logic busy1, output logic busy_at_done,
                            output logic [63:0] ord, output logic miss, output logic dup);
      int cyc;
      done_cyc     = 0;
      n_done       = 0;
      busy_at_done = 1'b1;
      ord          = '0;
      miss         = 1'b0;
      dup          = 1'b0;
      i_blocks = blk;
      i_start  = 1'b1;
      @(posedge clk);
      #1;
      i_start  = 1'b0;
      i_blocks = '0;
      cyc      = 1;
      busy1    = o_busy;
      for (int k = 0; k < WIN; k++) begin
         if (o_done) begin
            n_done++;
            if (done_cyc == 0) begin
               done_cyc     = cyc;
               busy_at_done = o_busy;
               ord          = o_order;
               miss         = o_miss;
               dup          = o_dup;
            end
         end
         if (cyc == pulse_at) begin
            i_start    = 1'b1;
            i_pal_we   = 1'b1;
            i_pal_addr = 4'd1;
            i_pal_data = 24'h000001;
         end
         if (cyc == rst_at) begin
            i_rst = 1'b1;
            #1;
            chk("rst_busy",  384'(o_busy),  384'(0));
            chk("rst_done",  384'(o_done),  384'(0));
            chk("rst_order", 384'(o_order), 384'(0));
            chk("rst_miss",  384'(o_miss),  384'(0));
            chk("rst_dup",   384'(o_dup),   384'(0));
         end
         @(posedge clk);
         #1;
         i_start  = 1'b0;
         i_pal_we = 1'b0;
         i_rst    = 1'b0;
         cyc++;
      end
   endtask

   initial begin
      logic [383:0] blk;
      logic [63:0]  ord;
      logic         miss, dup, busy1, busy_d;
      int           dc, nd;

      i_rst      = 1'b1;
      i_start    = 1'b0;
      i_blocks   = '0;
      i_pal_we   = 1'b0;
      i_pal_addr = '0;
      i_pal_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy",  384'(o_busy),  384'(0));
      chk("reset_done",  384'(o_done),  384'(0));
      chk("reset_order", 384'(o_order), 384'(0));
      chk("reset_miss",  384'(o_miss),  384'(0));
      chk("reset_dup",   384'(o_dup),   384'(0));
      i_rst = 1'b0;
      @(posedge clk);
      #1;

      // Permutation
      blk = perm_blocks();
      run_frame(blk, 0, 0, dc, nd, busy1, busy_d, ord, miss, dup);
      exp_from_perm();
      chk("perm_latency",   384'(dc),     384'(LAT));
      chk("perm_busy1",     384'(busy1),  384'(1));
      chk("perm_busy_done", 384'(busy_d), 384'(0));
      chk("perm_ndone",     384'(nd),     384'(1));
      chk("perm_order",     384'(ord),    384'(pack_exp()));
      chk("perm_miss",      384'(miss),   384'(0));
      chk("perm_dup",       384'(dup),    384'(0));
      chk("perm_hold",      384'(o_order), 384'(pack_exp()));

      // Noise of 10 counts per channel
      run_frame(add_noise(perm_blocks()), 0, 0, dc, nd, busy1, busy_d, ord, miss, dup);
      chk("noise_order", 384'(ord),  384'(pack_exp()));
      chk("noise_miss",  384'(miss), 384'(0));

      // Far colour 404040 -> nearest 7f7f00 (index 7) at distance 190
      blk = perm_blocks();
      blk[0 +: 24] = 24'h404040;
      run_frame(blk, 0, 0, dc, nd, busy1, busy_d, ord, miss, dup);
      exp_from_perm();
      exp_idx[0] = 7;
      chk("miss_order", 384'(ord),  384'(pack_exp()));
      chk("miss_miss",  384'(miss), 384'(1));
      chk("miss_dup",   384'(dup),  384'(dupx(1'b1)));

      // Duplicate red tiles
      blk = perm_blocks();
      blk[4*24 +: 24] = 24'hff0000;
      blk[9*24 +: 24] = 24'hff0000;
      run_frame(blk, 0, 0, dc, nd, busy1, busy_d, ord, miss, dup);
      exp_from_perm();
      exp_idx[4] = 5;
      exp_idx[9] = 5;
      chk("dup_order", 384'(ord),  384'(pack_exp()));
      chk("dup_miss",  384'(miss), 384'(0));
      chk("dup_dup",   384'(dup),  384'(dupx(1'b1)));

      // Palette load while idle
      pal_write(4'd0, 24'h123456);
      blk = perm_blocks();
      blk[3*24 +: 24] = 24'h123456;
      run_frame(blk, 0, 0, dc, nd, busy1, busy_d, ord, miss, dup);
      exp_from_perm();
      chk("pal_order", 384'(ord),  384'(pack_exp()));
      chk("pal_miss",  384'(miss), 384'(0));
      chk("pal_dup",   384'(dup),  384'(0));

      // Stray start and palette write while busy at cycle 50
      run_frame(blk, 50, 0, dc, nd, busy1, busy_d, ord, miss, dup);
      chk("busy_start_latency", 384'(dc),  384'(LAT));
      chk("busy_start_ndone",   384'(nd),  384'(1));
      chk("busy_start_order",   384'(ord), 384'(pack_exp()));

      // Entry 1 must still be ffffff: 000001 lands on entry 15
      blk[11*24 +: 24] = 24'h000001;
      run_frame(blk, 0, 0, dc, nd, busy1, busy_d, ord, miss, dup);
      exp_idx[11] = 15;
      chk("busy_wr_order", 384'(ord), 384'(pack_exp()));
      chk("busy_wr_dup",   384'(dup), 384'(dupx(1'b1)));

      // Tie: entry 3 = ff7e00, tile ff3f00 is 63 from both entry 3 and entry 5
      pal_write(4'd3, 24'hff7e00);
      blk = perm_blocks();
      blk[3*24 +: 24] = 24'h123456;
      blk[0 +: 24]    = 24'hff3f00;
      run_frame(blk, 0, 0, dc, nd, busy1, busy_d, ord, miss, dup);
      exp_from_perm();
      exp_idx[0] = 3;
      chk("tie_order", 384'(ord),  384'(pack_exp()));
      chk("tie_miss",  384'(miss), 384'(1));
      chk("tie_dup",   384'(dup),  384'(dupx(1'b1)));

      // Reset at cycle 100 aborts the frame
      run_frame(perm_blocks(), 0, 100, dc, nd, busy1, busy_d, ord, miss, dup);
      chk("abort_ndone", 384'(nd), 384'(0));
      chk("abort_busy",  384'(o_busy), 384'(0));

      // Default palette restored: entries 0 and 3 match their original colours again
      run_frame(perm_blocks(), 0, 0, dc, nd, busy1, busy_d, ord, miss, dup);
      exp_from_perm();
      chk("restore_latency", 384'(dc),   384'(LAT));
      chk("restore_order",   384'(ord),  384'(pack_exp()));
      chk("restore_miss",    384'(miss), 384'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
